// File: rtl/fetch_pc_sequencer_pkg.sv
// rtl/fetch_pc_sequencer_pkg.sv - shared types and constants for the fetch PC sequencer
// Contents: fetch_state_e (IDLE/REQ/WAIT/DRAIN), INSTR_BYTES, ALIGN_MASK, is_misaligned()
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  localparam logic [31:0] INSTR_BYTES = 32'd4;
  localparam logic [1:0]  ALIGN_MASK  = 2'b11;

  // No compressed instructions, so any set low bit is a misaligned target.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] & ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_pc_sequencer_if.sv
// rtl/fetch_pc_sequencer_if.sv - fetch front-end bus: imem request/response, decode handoff, redirect, exceptions
// master: sequencer side (drives imem_req_*, if_valid/if_pc/if_instr, flush, exc_*)
// slave : environment side (drives imem_req_ready, imem_rsp_*, if_ready, ex_redirect_*)
interface fetch_pc_sequencer_if;

  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        ex_redirect_valid;
  logic [31:0] ex_redirect_target;
  logic        flush;
  logic        exc_misaligned;
  logic [31:0] exc_tval;

  modport master (
    output imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr,
           flush, exc_misaligned, exc_tval,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
           ex_redirect_valid, ex_redirect_target
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr,
           flush, exc_misaligned, exc_tval,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
           ex_redirect_valid, ex_redirect_target
  );

endinterface

// File: rtl/fetch_pc_sequencer_buf.sv
// rtl/fetch_pc_sequencer_buf.sv - one-entry {pc, instr} holding register between fetch and decode
// Ports: clk, rst_n; set_valid/set_pc/set_instr load an entry; clear drops it;
//        out_valid/out_ready/out_pc/out_instr face decode.
module fetch_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        set_valid,
  input  logic [31:0] set_pc,
  input  logic [31:0] set_instr,
  input  logic        clear,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
);

  // clear (redirect) beats a same-cycle load; a load beats a consume because a
  // request is only issued once the previous entry is leaving.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_instr <= '0;
    end else if (clear) begin
      out_valid <= 1'b0;
    end else if (set_valid) begin
      out_valid <= 1'b1;
      out_pc    <= set_pc;
      out_instr <= set_instr;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_pc_sequencer.sv
// rtl/fetch_pc_sequencer.sv - fetch PC owner: one-at-a-time imem fetch, decode buffer, redirect/flush/misaligned trap
// Parameters: RESET_PC (pc after reset), TRAP_VEC (pc after a misaligned redirect)
// Ports: clk, rst_n (sync, active-low), bus (fetch_pc_sequencer_if.master)
module fetch_pc_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic                        clk,
  input  logic                        rst_n,
  fetch_pc_sequencer_if.master        bus
);

  fetch_state_e state, state_n;
  logic [31:0]  pc, pc_n;
  logic         flush_q, exc_q;
  logic [31:0]  tval_q;
  logic         buf_set;
  logic         buf_valid;
  logic [31:0]  buf_pc, buf_instr;
  logic         req_valid, req_fire;
  logic         redirect, redirect_mis;

  // Request may go out while decode is draining the buffer this cycle, which
  // is what allows one instruction every two cycles.
  assign req_valid    = (state == REQ) && (!buf_valid || bus.if_ready);
  assign req_fire     = req_valid && bus.imem_req_ready;
  assign redirect     = bus.ex_redirect_valid;
  assign redirect_mis = is_misaligned(bus.ex_redirect_target);

  always_comb begin
    state_n = state;
    pc_n    = pc;
    buf_set = 1'b0;
    unique case (state)
      IDLE:  state_n = REQ;
      REQ:   if (req_fire) state_n = WAIT;
      WAIT:  if (bus.imem_rsp_valid) begin
               buf_set = 1'b1;
               pc_n    = pc + INSTR_BYTES;
               state_n = REQ;
             end
      DRAIN: if (bus.imem_rsp_valid) state_n = REQ;
      default: state_n = IDLE;
    endcase
    if (redirect) begin
      buf_set = 1'b0;
      pc_n    = redirect_mis ? TRAP_VEC : bus.ex_redirect_target;
      // Drain only if a response is still owed after this edge.
      if ((state == WAIT  && !bus.imem_rsp_valid) ||
          (state == DRAIN && !bus.imem_rsp_valid) ||
          (state == REQ   && req_fire))
        state_n = DRAIN;
      else
        state_n = REQ;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      flush_q <= 1'b0;
      exc_q   <= 1'b0;
      tval_q  <= '0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      flush_q <= redirect;
      exc_q   <= redirect && redirect_mis;
      if (redirect && redirect_mis) tval_q <= bus.ex_redirect_target;
    end
  end

  fetch_buf u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_valid (buf_set),
    .set_pc    (pc),
    .set_instr (bus.imem_rsp_data),
    .clear     (redirect),
    .out_ready (bus.if_ready),
    .out_valid (buf_valid),
    .out_pc    (buf_pc),
    .out_instr (buf_instr)
  );

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc;
  assign bus.if_valid       = buf_valid;
  assign bus.if_pc          = buf_pc;
  assign bus.if_instr       = buf_instr;
  assign bus.flush          = flush_q;
  assign bus.exc_misaligned = exc_q;
  assign bus.exc_tval       = tval_q;

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// tb/tb_fetch_pc_sequencer.sv - self-checking bench for fetch_pc_sequencer
module tb_fetch_pc_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_pc_sequencer_if bus ();
  fetch_pc_sequencer_if bus2 ();

  fetch_pc_sequencer #(.RESET_PC(32'h0000_0000), .TRAP_VEC(32'h0000_0100)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  fetch_pc_sequencer #(.RESET_PC(32'hFFFF_FFFC), .TRAP_VEC(32'h0000_0100)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );

  int tests = 0;
  int fails = 0;
  int ncons = 0;
  int n2    = 0;

  logic [63:0] q[$];
  logic [31:0] exp_pc, exp2_pc;
  logic        exp_flush, exp_exc;
  logic        chk_en;
  int          data_mode;
  int          mem_lat;
  logic        mem_pending;
  int          mem_cnt;
  logic [31:0] mem_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] word(input logic [31:0] a);
    return (data_mode == 0) ? 32'h0000_0013 : (a ^ 32'h5A5A_0013);
  endfunction

  // One clock cycle: sample/check mid-cycle, then advance models after the edge.
  task automatic tick();
    logic hs, hs2, cons, red, rst_s;
    logic [31:0] tgt;
    logic [63:0] e;
    #3;
    rst_s = rst_n;
    hs    = bus.imem_req_valid && bus.imem_req_ready;
    hs2   = bus2.imem_req_valid && bus2.imem_req_ready;
    cons  = bus.if_valid && bus.if_ready;
    red   = bus.ex_redirect_valid;
    tgt   = bus.ex_redirect_target;
    if (chk_en) begin
      chk("flush", bus.flush, exp_flush);
      chk("exc_misaligned", bus.exc_misaligned, exp_exc);
      if (bus.if_valid && !bus.if_ready) chk("no_req_when_full", bus.imem_req_valid, 1'b0);
      if (hs) chk("req_addr", bus.imem_req_addr, exp_pc);
      if (hs2) begin
        chk("dut2_req_addr", bus2.imem_req_addr, exp2_pc);
        n2++;
      end
      if (cons) begin
        ncons++;
        if (q.size() == 0) chk("unexpected_instr_pc", bus.if_pc, 32'hDEAD_BEEF);
        else begin
          e = q.pop_front();
          chk("if_pc", bus.if_pc, e[63:32]);
          chk("if_instr", bus.if_instr, e[31:0]);
        end
      end
    end
    @(posedge clk);
    #1;
    bus.imem_rsp_valid  = 1'b0;
    bus2.imem_rsp_valid = 1'b0;
    if (!rst_s) begin
      mem_pending = 1'b0;
      q.delete();
      exp_pc    = 32'h0000_0000;
      exp2_pc   = 32'hFFFF_FFFC;
      exp_flush = 1'b0;
      exp_exc   = 1'b0;
    end else begin
      if (mem_pending) begin
        mem_cnt--;
        if (mem_cnt <= 0) begin
          bus.imem_rsp_valid = 1'b1;
          bus.imem_rsp_data  = mem_data;
          mem_pending = 1'b0;
        end
      end
      if (hs) begin
        mem_data = word(exp_pc);
        q.push_back({exp_pc, mem_data});
        exp_pc = exp_pc + 32'd4;
        if (mem_lat <= 1) begin
          bus.imem_rsp_valid = 1'b1;
          bus.imem_rsp_data  = mem_data;
        end else begin
          mem_pending = 1'b1;
          mem_cnt     = mem_lat - 1;
        end
      end
      if (hs2) begin
        exp2_pc = exp2_pc + 32'd4;
        bus2.imem_rsp_valid = 1'b1;
        bus2.imem_rsp_data  = 32'h0000_0013;
      end
      exp_flush = red;
      exp_exc   = red && (tgt[1:0] != 2'b00);
      if (red) begin
        q.delete();
        exp_pc = (tgt[1:0] != 2'b00) ? 32'h0000_0100 : tgt;
      end
    end
  endtask

  task automatic redirect_to(input logic [31:0] tgt);
    bus.ex_redirect_valid  = 1'b1;
    bus.ex_redirect_target = tgt;
    tick();
    bus.ex_redirect_valid  = 1'b0;
  endtask

  initial begin
    int c0;
    logic ok;
    rst_n = 1'b0;
    chk_en = 1'b0;
    data_mode = 0;
    mem_lat = 1;
    mem_pending = 1'b0;
    mem_cnt = 0;
    mem_data = '0;
    exp_pc = 32'h0; exp2_pc = 32'hFFFF_FFFC;
    exp_flush = 1'b0; exp_exc = 1'b0;
    bus.imem_req_ready = 1'b1;  bus2.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;  bus2.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;    bus2.imem_rsp_data  = '0;
    bus.if_ready = 1'b1;        bus2.if_ready = 1'b1;
    bus.ex_redirect_valid = 1'b0;  bus2.ex_redirect_valid = 1'b0;
    bus.ex_redirect_target = '0;   bus2.ex_redirect_target = '0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    tick();
    tick();

    // Reset state
    chk("rst_req_valid", bus.imem_req_valid, 1'b0);
    chk("rst_req_addr", bus.imem_req_addr, 32'h0);
    chk("rst_if_valid", bus.if_valid, 1'b0);
    chk("rst_flush", bus.flush, 1'b0);
    chk("rst_exc", bus.exc_misaligned, 1'b0);
    chk("rst_if_pc", bus.if_pc, 32'h0);
    chk("rst_if_instr", bus.if_instr, 32'h0);
    chk("rst_exc_tval", bus.exc_tval, 32'h0);
    chk("rst2_req_addr", bus2.imem_req_addr, 32'hFFFF_FFFC);

    // Release: cycle 1 idle, cycle 2 first request at RESET_PC
    rst_n = 1'b1;
    chk("cyc1_req_valid", bus.imem_req_valid, 1'b0);
    tick();
    chk("cyc2_req_valid", bus.imem_req_valid, 1'b1);
    chk("cyc2_req_addr", bus.imem_req_addr, 32'h0);
    repeat (3) tick();

    // Zero-wait steady state: one instruction every two cycles
    c0 = ncons;
    repeat (10) tick();
    chk("throughput_10cyc", ncons - c0, 5);

    // Decode stall: buffer holds, no new request
    bus.if_ready = 1'b0;
    for (int i = 0; i < 20 && !bus.if_valid; i++) tick();
    chk("stall_if_valid", bus.if_valid, 1'b1);
    repeat (5) begin
      tick();
      if (q.size() != 0) begin
        chk("stall_if_pc", bus.if_pc, q[0][63:32]);
        chk("stall_if_instr", bus.if_instr, q[0][31:0]);
      end
      chk("stall_req_valid", bus.imem_req_valid, 1'b0);
    end
    bus.if_ready = 1'b1;
    repeat (4) tick();

    // Redirect in WAIT with a slow memory: response drained
    data_mode = 1;
    mem_lat = 3;
    for (int i = 0; i < 20 && !mem_pending; i++) tick();
    chk("wait_reached", mem_pending, 1'b1);
    redirect_to(32'h0000_0200);
    chk("wait_redir_flush", bus.flush, 1'b1);
    chk("wait_redir_if_valid", bus.if_valid, 1'b0);
    for (int i = 0; i < 20 && !bus.imem_req_valid; i++) tick();
    chk("drain_next_addr", bus.imem_req_addr, 32'h0000_0200);
    for (int i = 0; i < 20 && !bus.if_valid; i++) tick();
    chk("drain_if_pc", bus.if_pc, 32'h0000_0200);
    chk("drain_if_instr", bus.if_instr, 32'h0000_0200 ^ 32'h5A5A_0013);
    mem_lat = 1;
    repeat (4) tick();

    // Misaligned target traps
    redirect_to(32'h0000_0302);
    chk("mis_exc", bus.exc_misaligned, 1'b1);
    chk("mis_tval", bus.exc_tval, 32'h0000_0302);
    tick();
    chk("mis_exc_pulse", bus.exc_misaligned, 1'b0);
    chk("mis_tval_hold", bus.exc_tval, 32'h0000_0302);
    for (int i = 0; i < 20 && !bus.imem_req_valid; i++) tick();
    chk("mis_next_addr", bus.imem_req_addr, 32'h0000_0100);
    repeat (4) tick();

    // Redirect coincident with response in WAIT: no drain
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (bus.imem_rsp_valid) ok = 1'b1;
      else tick();
    end
    chk("rsp_seen", ok, 1'b1);
    redirect_to(32'h0000_0400);
    chk("coinc_req_valid", bus.imem_req_valid, 1'b1);
    chk("coinc_req_addr", bus.imem_req_addr, 32'h0000_0400);
    repeat (4) tick();

    // Redirect on a request handshake: the following response is drained
    for (int i = 0; i < 20 && !bus.imem_req_valid; i++) tick();
    redirect_to(32'h0000_0600);
    for (int i = 0; i < 20 && !bus.imem_req_valid; i++) tick();
    chk("hs_redir_addr", bus.imem_req_addr, 32'h0000_0600);
    repeat (6) tick();

    // Reset mid-fetch abandons the request
    mem_lat = 3;
    for (int i = 0; i < 20 && !mem_pending; i++) tick();
    rst_n = 1'b0;
    tick();
    tick();
    chk("midrst_if_valid", bus.if_valid, 1'b0);
    chk("midrst_addr", bus.imem_req_addr, 32'h0);
    mem_lat = 1;
    rst_n = 1'b1;
    chk("midrst_cyc1_req", bus.imem_req_valid, 1'b0);
    tick();
    chk("midrst_cyc2_req", bus.imem_req_valid, 1'b1);
    chk("midrst_cyc2_addr", bus.imem_req_addr, 32'h0);
    repeat (6) tick();

    chk("dut2_fetches_seen", (n2 >= 2) ? 32'd1 : 32'd0, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
